// File: rtl/hc595_pkg.sv
// Shared types and pin idle levels for the 74HC595 serial driver.
package hc595_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SH_LO = 3'd1,
      SH_HI = 3'd2,
      LT_LO = 3'd3,
      LT_HI = 3'd4
   } state_t;

   localparam logic SHCP_IDLE = 1'b1;
   localparam logic STCP_IDLE = 1'b1;
   localparam logic OE_OFF    = 1'b1;

endpackage

// File: rtl/hc595_phase_tick.sv
// Phase counter: ticks on the last cycle of every CLK_DIV-long phase.
module hc595_phase_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_restart,
   output logic o_tick
);

   localparam int CW = $clog2(CLK_DIV) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_restart) begin
         r_cnt <= '0;
      end else if (o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/hc595_serial_driver.sv
// Serializes a parallel word onto DS/SHCP/STCP/OE for cascaded 74HC595 chips.
//
// state | meaning
// IDLE  | bus idle (SHCP=1, STCP=1), ready for a load
// SH_LO | SHCP low, DS presents the current bit
// SH_HI | SHCP high (shift edge at entry), DS held
// LT_LO | STCP low, DS=0
// LT_HI | STCP high (latch edge at entry), done on exit
module hc595_serial_driver
   import hc595_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   input  logic              oe_en,
   output logic              ready,
   output logic              done,
   output logic              DS,
   output logic              SHCP,
   output logic              STCP,
   output logic              OE
);

   localparam int BW = $clog2(DATA_W) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_sr, w_sr_nxt;
   logic [BW-1:0]     r_bit, w_bit_nxt;
   logic              w_tick;
   logic              w_ds_nxt;

   function automatic logic cur_bit(input logic [DATA_W-1:0] s);
      return (MSB_FIRST != 0) ? s[DATA_W-1] : s[0];
   endfunction

   hc595_phase_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_phase (
      .clk       (clk),
      .rst       (rst),
      .i_restart (r_state == IDLE),
      .o_tick    (w_tick)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_bit_nxt   = r_bit;
      case (r_state)
         IDLE: begin
            if (load) begin
               w_state_nxt = SH_LO;
               w_sr_nxt    = data_in;
               w_bit_nxt   = '0;
            end
         end
         SH_LO: begin
            if (w_tick) w_state_nxt = SH_HI;
         end
         SH_HI: begin
            if (w_tick) begin
               w_sr_nxt    = (MSB_FIRST != 0) ? (r_sr << 1) : (r_sr >> 1);
               w_bit_nxt   = r_bit + BW'(1);
               w_state_nxt = (r_bit < LAST_BIT) ? SH_LO : LT_LO;
            end
         end
         LT_LO: begin
            if (w_tick) w_state_nxt = LT_HI;
         end
         LT_HI: begin
            if (w_tick) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      // Pins are registered from next state, so DS is valid on the first SH_LO cycle.
      w_ds_nxt = ((w_state_nxt == SH_LO) || (w_state_nxt == SH_HI)) ? cur_bit(w_sr_nxt) : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_sr    <= '0;
         r_bit   <= '0;
         ready   <= 1'b1;
         done    <= 1'b0;
         DS      <= 1'b0;
         SHCP    <= SHCP_IDLE;
         STCP    <= STCP_IDLE;
         OE      <= OE_OFF;
      end else begin
         r_state <= w_state_nxt;
         r_sr    <= w_sr_nxt;
         r_bit   <= w_bit_nxt;
         ready   <= (w_state_nxt == IDLE);
         done    <= (r_state == LT_HI) && w_tick;
         DS      <= w_ds_nxt;
         SHCP    <= (w_state_nxt != SH_LO);
         STCP    <= (w_state_nxt != LT_LO);
         OE      <= ~oe_en;
      end
   end

endmodule

// File: tb/tb_hc595_serial_driver.sv
// Scoreboard bench: 8-bit MSB-first/CLK_DIV=4 and 16-bit LSB-first/CLK_DIV=1 drivers.
module tb_hc595_serial_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, load_a, oe_en_a, ready_a, done_a, ds_a, shcp_a, stcp_a, oe_a;
   logic [7:0]  data_a;
   logic        rst_b, load_b, oe_en_b, ready_b, done_b, ds_b, shcp_b, stcp_b, oe_b;
   logic [15:0] data_b;

   hc595_serial_driver #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1)) dut_a (
      .clk(clk), .rst(rst_a), .data_in(data_a), .load(load_a), .oe_en(oe_en_a),
      .ready(ready_a), .done(done_a), .DS(ds_a), .SHCP(shcp_a), .STCP(stcp_a), .OE(oe_a));

   hc595_serial_driver #(.DATA_W(16), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
      .clk(clk), .rst(rst_b), .data_in(data_b), .load(load_b), .oe_en(oe_en_b),
      .ready(ready_b), .done(done_b), .DS(ds_b), .SHCP(shcp_b), .STCP(stcp_b), .OE(oe_b));

   typedef struct {
      logic [15:0] word;
      int          lat;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic mon_on = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference 74HC595 for the 8-bit bus: shift on SHCP rise, latch on STCP rise.
   logic [7:0] m_sr_a = 8'h00;
   logic [7:0] led_a  = 8'h00;
   always @(posedge shcp_a) m_sr_a <= {m_sr_a[6:0], ds_a};
   always @(posedge stcp_a) led_a <= m_sr_a;

   logic exp_oe_a = 1'b1, exp_oe_b = 1'b1;
   always @(posedge clk) begin
      exp_oe_a <= rst_a ? 1'b1 : ~oe_en_a;
      exp_oe_b <= rst_b ? 1'b1 : ~oe_en_b;
   end

   logic [15:0] cap_a, cap_b;
   int   shr_a, str_a, start_a, stcp_tot_a = 0, done_cnt_a = 0;
   int   shr_b, str_b, start_b, done_cnt_b = 0;
   logic p_shcp_a = 1'b1, p_stcp_a = 1'b1, p_ready_a = 1'b1;
   logic p_shcp_b = 1'b1, p_stcp_b = 1'b1, p_ready_b = 1'b1;

   always @(negedge clk) begin
      if (mon_on) begin
         exp_t e;
         chk("a_oe", oe_a, exp_oe_a);
         if (!ready_a && p_ready_a) begin
            start_a = cyc; cap_a = '0; shr_a = 0; str_a = 0;
         end
         if (shcp_a && !p_shcp_a) begin cap_a = {cap_a[14:0], ds_a}; shr_a++; end
         if (stcp_a && !p_stcp_a) begin str_a++; stcp_tot_a++; end
         if (done_a) begin
            done_cnt_a++;
            if (q_a.size() == 0) begin
               errors++;
               $display("FAIL a_unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               e = q_a.pop_front();
               chk("a_word", {8'h00, cap_a[7:0]}, e.word);
               chk("a_shcp_rises", shr_a, 8);
               chk("a_stcp_rises", str_a, 1);
               chk("a_latency", cyc - start_a, e.lat);
            end
         end
      end
      p_shcp_a = shcp_a; p_stcp_a = stcp_a; p_ready_a = ready_a;
   end

   always @(negedge clk) begin
      if (mon_on) begin
         exp_t e;
         chk("b_oe", oe_b, exp_oe_b);
         if (!ready_b && p_ready_b) begin
            start_b = cyc; cap_b = '0; shr_b = 0; str_b = 0;
         end
         if (shcp_b && !p_shcp_b) begin cap_b = {cap_b[14:0], ds_b}; shr_b++; end
         if (stcp_b && !p_stcp_b) str_b++;
         if (done_b) begin
            done_cnt_b++;
            if (q_b.size() == 0) begin
               errors++;
               $display("FAIL b_unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
               e = q_b.pop_front();
               chk("b_word", cap_b, e.word);
               chk("b_shcp_rises", shr_b, 16);
               chk("b_stcp_rises", str_b, 1);
               chk("b_latency", cyc - start_b, e.lat);
            end
         end
      end
      p_shcp_b = shcp_b; p_stcp_b = stcp_b; p_ready_b = ready_b;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int bad;
      int n;
      int stcp_before;
      rst_a = 1'b1; load_a = 1'b0; oe_en_a = 1'b0; data_a = '0;
      rst_b = 1'b1; load_b = 1'b0; oe_en_b = 1'b0; data_b = '0;
      repeat (5) step();
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      chk("rst_ready", ready_a, 1'b1);
      chk("rst_done",  done_a,  1'b0);
      chk("rst_ds",    ds_a,    1'b0);
      chk("rst_shcp",  shcp_a,  1'b1);
      chk("rst_stcp",  stcp_a,  1'b1);
      chk("rst_oe",    oe_a,    1'b1);
      chk("rst_b_pins", {ready_b, done_b, ds_b, shcp_b, stcp_b, oe_b}, 6'b100111);
      mon_on = 1'b1;

      // Idle bus must stay quiet with load low.
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if ({ds_a, shcp_a, stcp_a, oe_a, ready_a, done_a} !== 6'b011110) bad++;
      end
      chk("idle_quiet", bad, 0);

      // Single 8'hF0 transfer, then enable outputs on the reference chip.
      step();
      data_a = 8'hF0; load_a = 1'b1;
      q_a.push_back('{16'h00F0, 72});
      step();
      load_a = 1'b0;
      repeat (75) step();
      oe_en_a = 1'b1;
      step(); step();
      chk("led_f0", led_a, 8'hF0);
      chk("oe_enabled", oe_a, 1'b0);

      // Load held high: two transfers separated by exactly one IDLE cycle.
      data_a = 8'hA5; load_a = 1'b1;
      q_a.push_back('{16'h00A5, 72});
      q_a.push_back('{16'h003C, 72});
      step();
      data_a = 8'h3C;
      n = 0;
      do begin @(negedge clk); n++; end while (!ready_a && n < 200);
      chk("b2b_wait_bounded", (n < 200), 1'b1);
      chk("b2b_done_in_gap", done_a, 1'b1);
      step();
      load_a = 1'b0;
      @(negedge clk);
      chk("b2b_gap_ready", ready_a, 1'b0);
      chk("b2b_gap_shcp", shcp_a, 1'b0);
      repeat (80) step();
      chk("led_3c", led_a, 8'h3C);

      // Reset mid-transfer: no latch edge, chip keeps 8'h3C.
      data_a = 8'h55; load_a = 1'b1;
      step();
      load_a = 1'b0;
      stcp_before = stcp_tot_a;
      repeat (29) step();
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      @(negedge clk);
      chk("abort_pins", {ready_a, done_a, ds_a, shcp_a, stcp_a, oe_a}, 6'b100111);
      repeat (80) step();
      chk("abort_no_stcp", stcp_tot_a - stcp_before, 0);
      chk("abort_led_kept", led_a, 8'h3C);

      // OE follows ~oe_en during a transfer without disturbing the shift timing.
      oe_en_a = 1'b0;
      data_a = 8'h81; load_a = 1'b1;
      q_a.push_back('{16'h0081, 72});
      step();
      load_a = 1'b0;
      repeat (10) step();
      oe_en_a = 1'b1;
      repeat (20) step();
      oe_en_a = 1'b0;
      repeat (50) step();
      chk("led_81", led_a, 8'h81);
      chk("a_done_count", done_cnt_a, 4);

      // 16-bit LSB-first, CLK_DIV=1: loads while busy are ignored.
      data_b = 16'h0001; load_b = 1'b1;
      q_b.push_back('{16'h8000, 34});
      step();
      load_b = 1'b0;
      repeat (9) step();
      data_b = 16'hFFFF; load_b = 1'b1;
      step();
      load_b = 1'b0;
      repeat (14) step();
      load_b = 1'b1;
      step();
      load_b = 1'b0;
      repeat (20) step();
      chk("b_one_done", done_cnt_b, 1);
      oe_en_b = 1'b1;
      data_b = 16'hC3A5; load_b = 1'b1;
      q_b.push_back('{16'hA5C3, 34});
      step();
      load_b = 1'b0;
      repeat (10) step();
      oe_en_b = 1'b0;
      repeat (40) step();
      chk("b_done_count", done_cnt_b, 2);
      chk("a_queue_drained", q_a.size(), 0);
      chk("b_queue_drained", q_b.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
